// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Single-issue front end for the external 19-bit combinational ALU,
//            with a 16-entry register file and valid/ready result port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [18:0] instr,
    output logic [4:0]  alu_opcode,
    output logic [18:0] alu_a,
    output logic [18:0] alu_b,
    input  logic [18:0] alu_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [18:0] res_data,
    output logic [3:0]  res_rd,
    output logic        res_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [4:0]  c_OP_DIV    = 5'b00011;
    localparam logic [4:0]  c_OP_LDI    = 5'b11100;
    localparam logic [4:0]  c_OP_MAXLO  = 5'b01001;
    localparam logic [4:0]  c_OP_MINHI  = 5'b11110;
    localparam logic [18:0] c_DIV0_VAL  = 19'h7FFFF;

    logic [1:0]  r_state;
    logic [18:0] r_rf [16];
    logic [4:0]  r_alu_opcode;
    logic [18:0] r_alu_a;
    logic [18:0] r_alu_b;
    logic [3:0]  r_rd;
    logic [9:0]  r_imm;
    logic [18:0] r_res_data;
    logic [3:0]  r_res_rd;
    logic        r_res_err;

    logic        w_accept;
    logic        w_exec;
    logic [18:0] w_result;
    logic        w_err;

    assign instr_ready = (r_state == S_IDLE);
    assign res_valid   = (r_state == S_RESP);
    assign alu_opcode  = r_alu_opcode;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign res_data    = r_res_data;
    assign res_rd      = r_res_rd;
    assign res_err     = r_res_err;

    assign w_accept = instr_valid && (r_state == S_IDLE);
    assign w_exec   = (r_state == S_EXEC);

    // Result selection; LDI, divide-by-zero and undefined ops bypass the ALU.
    always_comb begin
        w_result = '0;
        w_err    = 1'b0;
        if (r_alu_opcode <= c_OP_MAXLO || r_alu_opcode >= c_OP_MINHI) begin
            if (r_alu_opcode == c_OP_DIV && r_alu_b == '0) begin
                w_result = c_DIV0_VAL;
                w_err    = 1'b1;
            end else begin
                w_result = alu_result;
            end
        end else if (r_alu_opcode == c_OP_LDI) begin
            w_result = {9'b0, r_imm};
        end else begin
            w_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (instr_valid) r_state <= S_EXEC;
                S_EXEC:  r_state <= S_RESP;
                S_RESP:  if (res_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // rf[0] is never written, so it reads zero without a read-side mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_exec && !w_err && r_rd != 4'd0) begin
            r_rf[r_rd] <= w_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_opcode <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rd         <= '0;
            r_imm        <= '0;
        end else if (w_accept) begin
            r_alu_opcode <= instr[18:14];
            r_alu_a      <= r_rf[instr[9:6]];
            r_alu_b      <= r_rf[instr[5:2]];
            r_rd         <= instr[13:10];
            r_imm        <= instr[9:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_data <= '0;
            r_res_rd   <= '0;
            r_res_err  <= 1'b0;
        end else if (w_exec) begin
            r_res_data <= w_result;
            r_res_rd   <= r_rd;
            r_res_err  <= w_err;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Directed self-checking bench for alu_issue_ctrl with a small
//            behavioural ALU attached.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

    localparam logic [18:0] c_KEY = 19'h1A2B3;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [18:0] instr;
    logic [4:0]  alu_opcode;
    logic [18:0] alu_a;
    logic [18:0] alu_b;
    logic [18:0] alu_result;
    logic        res_valid;
    logic        res_ready;
    logic [18:0] res_data;
    logic [3:0]  res_rd;
    logic        res_err;

    int n_pass  = 0;
    int n_total = 0;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_rd      (res_rd),
        .res_err     (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ops whose ALU output must be ignored return junk so a leak is visible.
    always_comb begin
        case (alu_opcode)
            5'd0:    alu_result = alu_a + alu_b;
            5'd1:    alu_result = alu_a - alu_b;
            5'd2:    alu_result = alu_a & alu_b;
            5'd3:    alu_result = (alu_b == '0) ? 19'h12345 : alu_a / alu_b;
            5'd4:    alu_result = alu_a | alu_b;
            5'd5:    alu_result = alu_a ^ alu_b;
            5'd8:    alu_result = alu_a + 19'd1;
            5'd9:    alu_result = alu_a - 19'd1;
            5'd30:   alu_result = alu_a ^ c_KEY;
            5'd31:   alu_result = alu_a ^ c_KEY;
            default: alu_result = 19'h5A5A5;
        endcase
    end

    function automatic logic [18:0] enc(input logic [4:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, rd, rs1, rs2, 2'b00};
    endfunction

    function automatic logic [18:0] ldi(input logic [3:0] rd, input logic [9:0] imm);
        return {5'b11100, rd, imm};
    endfunction

    // Offers one instruction, returns edges from accept until res_valid (99 on timeout).
    task automatic issue(input logic [18:0] ins, output int lat);
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!res_valid) lat = 99;
    endtask

    task automatic retire();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        #3;
        n_total++; if (instr_ready !== 1'b1 || res_valid !== 1'b0) $display("FAIL rst_hs: ready=%b valid=%b want 1/0", instr_ready, res_valid); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(ldi(4'd1, 10'h3FF), lat);
        n_total++; if (res_data !== 19'h003FF) $display("FAIL pre_rst_ldi: got %h want 003ff", res_data); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (instr_ready !== 1'b1 || res_valid !== 1'b0) $display("FAIL midrst_hs: ready=%b valid=%b want 1/0", instr_ready, res_valid); else n_pass++;
        n_total++; if ({res_data, res_rd, res_err} !== '0) $display("FAIL midrst_res: data=%h rd=%h err=%b want 0", res_data, res_rd, res_err); else n_pass++;
        n_total++; if ({alu_opcode, alu_a, alu_b} !== '0) $display("FAIL midrst_alu: op=%h a=%h b=%h want 0", alu_opcode, alu_a, alu_b); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        issue(enc(5'd0, 4'd3, 4'd0, 4'd0), lat);
        n_total++; if (res_data !== 19'h0 || res_err !== 1'b0) $display("FAIL add_r0r0: data=%h err=%b want 0/0", res_data, res_err); else n_pass++;
        retire();
        issue(enc(5'd0, 4'd3, 4'd1, 4'd0), lat);
        n_total++; if (res_data !== 19'h0) $display("FAIL rf_cleared: r1=%h want 0", res_data); else n_pass++;
        retire();
    endtask

    task automatic test_ldi_add();
        int lat;
        issue(ldi(4'd1, 10'h3FF), lat);
        retire();
        issue(ldi(4'd2, 10'd5), lat);
        n_total++; if (res_data !== 19'h00005 || res_rd !== 4'd2) $display("FAIL ldi5: data=%h rd=%h want 00005/2", res_data, res_rd); else n_pass++;
        retire();
        issue(enc(5'd0, 4'd3, 4'd1, 4'd2), lat);
        n_total++; if (res_data !== 19'h00404 || res_rd !== 4'd3 || res_err !== 1'b0) $display("FAIL add: data=%h rd=%h err=%b want 00404/3/0", res_data, res_rd, res_err); else n_pass++;
        // Accept edge N, res_valid after edge N+1: one edge beyond the accept.
        n_total++; if (lat !== 1) $display("FAIL latency: got %0d want 1", lat); else n_pass++;
        n_total++; if (alu_opcode !== 5'd0 || alu_a !== 19'h003FF || alu_b !== 19'h00005) $display("FAIL alu_ops: op=%h a=%h b=%h want 0/003ff/00005", alu_opcode, alu_a, alu_b); else n_pass++;
        retire();
    endtask

    task automatic test_wrap_r0();
        int lat;
        issue(enc(5'd1, 4'd4, 4'd2, 4'd1), lat);
        n_total++; if (res_data !== 19'h7FC06) $display("FAIL sub_wrap: got %h want 7fc06", res_data); else n_pass++;
        retire();
        issue(enc(5'd8, 4'd0, 4'd1, 4'd0), lat);
        n_total++; if (res_data !== 19'h00400 || res_rd !== 4'd0 || res_err !== 1'b0) $display("FAIL inc_r0: data=%h rd=%h err=%b want 00400/0/0", res_data, res_rd, res_err); else n_pass++;
        retire();
        issue(enc(5'd0, 4'd11, 4'd0, 4'd0), lat);
        n_total++; if (res_data !== 19'h0) $display("FAIL r0_zero: got %h want 0", res_data); else n_pass++;
        retire();
        issue(enc(5'd0, 4'd12, 4'd4, 4'd0), lat);
        n_total++; if (res_data !== 19'h7FC06) $display("FAIL r4_wb: got %h want 7fc06", res_data); else n_pass++;
        retire();
    endtask

    task automatic test_faults();
        int lat;
        issue(enc(5'd3, 4'd5, 4'd1, 4'd0), lat);
        n_total++; if (res_err !== 1'b1 || res_data !== 19'h7FFFF) $display("FAIL div0: err=%b data=%h want 1/7ffff", res_err, res_data); else n_pass++;
        retire();
        issue(enc(5'd0, 4'd6, 4'd5, 4'd0), lat);
        n_total++; if (res_data !== 19'h0 || res_err !== 1'b0) $display("FAIL r5_unwritten: data=%h err=%b want 0/0", res_data, res_err); else n_pass++;
        retire();
        issue(enc(5'd10, 4'd13, 4'd1, 4'd2), lat);
        n_total++; if (res_err !== 1'b1 || res_data !== 19'h0) $display("FAIL op0a: err=%b data=%h want 1/0", res_err, res_data); else n_pass++;
        retire();
        issue(enc(5'd29, 4'd13, 4'd1, 4'd2), lat);
        n_total++; if (res_err !== 1'b1 || res_data !== 19'h0) $display("FAIL op1d: err=%b data=%h want 1/0", res_err, res_data); else n_pass++;
        retire();
        issue(enc(5'd3, 4'd5, 4'd1, 4'd2), lat);
        n_total++; if (res_err !== 1'b0 || res_data !== 19'h000CC) $display("FAIL div: err=%b data=%h want 0/000cc", res_err, res_data); else n_pass++;
        retire();
    endtask

    task automatic test_crypto();
        int lat;
        issue(enc(5'd30, 4'd7, 4'd1, 4'd0), lat);
        n_total++; if (res_data !== 19'h1A14C) $display("FAIL encrypt: got %h want 1a14c", res_data); else n_pass++;
        retire();
        issue(enc(5'd31, 4'd8, 4'd7, 4'd0), lat);
        n_total++; if (res_data !== 19'h003FF) $display("FAIL decrypt: got %h want 003ff", res_data); else n_pass++;
        retire();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        issue(enc(5'd0, 4'd9, 4'd1, 4'd2), lat);
        bad = 0;
        instr       = enc(5'd1, 4'd10, 4'd2, 4'd1);
        instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (res_valid !== 1'b1 || instr_ready !== 1'b0 || res_data !== 19'h00404 ||
                res_rd !== 4'd9 || res_err !== 1'b0 || alu_opcode !== 5'd0) bad++;
        end
        instr_valid = 1'b0;
        n_total++; if (bad !== 0) $display("FAIL hold: %0d unstable cycles want 0 (last data=%h rd=%h)", bad, res_data, res_rd); else n_pass++;
        retire();
        n_total++; if (instr_ready !== 1'b1 || res_valid !== 1'b0) $display("FAIL release: ready=%b valid=%b want 1/0", instr_ready, res_valid); else n_pass++;
        issue(enc(5'd0, 4'd10, 4'd9, 4'd0), lat);
        n_total++; if (res_data !== 19'h00404 || lat !== 1) $display("FAIL b2b: data=%h lat=%0d want 00404/1", res_data, lat); else n_pass++;
        retire();
    endtask

    task automatic test_abort();
        int lat;
        int seen;
        @(negedge clk);
        instr       = ldi(4'd14, 10'h2AA);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (res_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        n_total++; if (seen !== 0) $display("FAIL abort_valid: res_valid high %0d cycles want 0", seen); else n_pass++;
        issue(enc(5'd0, 4'd15, 4'd14, 4'd0), lat);
        n_total++; if (res_data !== 19'h0) $display("FAIL abort_wb: r14=%h want 0", res_data); else n_pass++;
        retire();
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        res_ready   = 1'b0;
        test_reset();
        test_ldi_add();
        test_wrap_r0();
        test_faults();
        test_crypto();
        test_backpressure();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
